// File: rtl/gio_pkg.sv
// gio_pkg: shared constants for the gio_bank GPIO window.
//   Offsets within the 32-address window, window width and channel limits.
package gio_pkg;

  localparam int unsigned GIO_WIN_W  = 5;  // address bits decoded inside the window
  localparam int unsigned GIO_MAX_CH = 8;  // max output/input ports per instance
  localparam int unsigned GIO_BYTE_W = 8;  // port data width

  localparam logic [4:0] GIO_OFF_MASK  = 5'h10;
  localparam logic [4:0] GIO_OFF_FLAGS = 5'h11;
  localparam logic [4:0] GIO_OFF_RDBK  = 5'h08;

endpackage

// File: rtl/gio_sync_edge.sv
// gio_sync_edge: one 8-bit GPIO input channel.
//   Two-flop synchroniser, previous-value register and gated change strobe.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   arm   in   change detection enable
//   din   in   asynchronous input byte
//   sync  out  synchronised input byte
//   chg   out  high while the synchronised value differs from last cycle (when armed)
module gio_sync_edge
  import gio_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [GIO_BYTE_W-1:0] din,
  output logic [GIO_BYTE_W-1:0] sync,
  output logic                  chg
);

  logic [GIO_BYTE_W-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      // prev follows sync even while disarmed so arming never sees a stale difference
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign chg  = arm & (|(sync_q ^ prev_q));

endmodule

// File: rtl/gio_bank.sv
// gio_bank: PicoBlaze port-bus GPIO bank in an aligned 32-address window.
//   N_OUT output registers, N_IN synchronised inputs with sticky change flags,
//   a mask register and a registered level interrupt.
// Optional build macro: GIO_READBACK_EN -- reads at offset 0x08+k return output reg k.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   address    in   port address from core
//   value_in   in   write data from core
//   wen        in   write strobe
//   ren        in   read strobe
//   port_in    in   GPIO inputs, port k at [8k+7:8k]
//   port_out   out  output registers, port k at [8k+7:8k]
//   value_out  out  registered read data
//   interrupt  out  registered |(flags & mask)
module gio_bank
  import gio_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned N_OUT     = 1,
  parameter int unsigned N_IN      = 1,
  parameter logic [7:0]  OUT_RST   = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           address,
  input  logic [7:0]           value_in,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [8*N_IN-1:0]    port_in,
  output logic [8*N_OUT-1:0]   port_out,
  output logic [7:0]           value_out,
  output logic                 interrupt
);

  logic                 hit, wr, arm;
  logic [GIO_WIN_W-1:0] off;

  logic [7:0]      out_q [N_OUT];
  logic [7:0]      out_d [N_OUT];
  logic [7:0]      sync  [N_IN];
  logic [N_IN-1:0] chg, clr;
  logic [N_IN-1:0] mask_q, mask_d;
  logic [N_IN-1:0] flags_q, flags_d;
  logic [7:0]      rdata, value_out_q, value_out_d;
  logic            irq_q;
  logic [1:0]      cnt_q;

  assign hit = (address[7:5] == BASE_ADDR[7:5]);
  assign off = address[GIO_WIN_W-1:0];
  assign wr  = wen & hit;
  assign arm = (cnt_q == 2'd3);

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    gio_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .arm  (arm),
      .din  (port_in[8*k +: 8]),
      .sync (sync[k]),
      .chg  (chg[k])
    );
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign port_out[8*k +: 8] = out_q[k];
  end

  // Write side
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr    = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (wr && off == k[4:0]) out_d[k] = value_in;
    end
    if (wr && off == GIO_OFF_MASK)  mask_d = value_in[N_IN-1:0];
    if (wr && off == GIO_OFF_FLAGS) clr    = value_in[N_IN-1:0];
    // set is OR-ed after the clear so a same-cycle change wins
    flags_d = (flags_q & ~clr) | chg;
  end

  // Read side
  always_comb begin
    rdata = '0;
    if (off == GIO_OFF_MASK) begin
      rdata[N_IN-1:0] = mask_q;
    end else if (off == GIO_OFF_FLAGS) begin
      rdata[N_IN-1:0] = flags_q;
    end
    for (int k = 0; k < N_IN; k++) begin
      if (off == k[4:0]) rdata = sync[k];
    end
`ifdef GIO_READBACK_EN
    for (int k = 0; k < N_OUT; k++) begin
      if (off == GIO_OFF_RDBK + k[4:0]) rdata = out_q[k];
    end
`endif
    value_out_d = value_out_q;
    if (ren) value_out_d = hit ? rdata : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= OUT_RST;
      mask_q      <= '0;
      flags_q     <= '0;
      value_out_q <= '0;
      irq_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      mask_q      <= mask_d;
      flags_q     <= flags_d;
      value_out_q <= value_out_d;
      irq_q       <= |(flags_q & mask_q);
      if (!arm) cnt_q <= cnt_q + 2'd1;
    end
  end

  assign value_out = value_out_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_gio_bank.sv
// tb_gio_bank: directed table-driven bench for gio_bank
// (BASE_ADDR=8'h40, N_OUT=2, N_IN=2, OUT_RST=8'hA5).
module tb_gio_bank;

`ifdef GIO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  address, value_in, value_out;
  logic        wen, ren, interrupt;
  logic [15:0] port_in, port_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gio_bank #(
    .BASE_ADDR (8'h40),
    .N_OUT     (2),
    .N_IN      (2),
    .OUT_RST   (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .value_in  (value_in),
    .wen       (wen),
    .ren       (ren),
    .port_in   (port_in),
    .port_out  (port_out),
    .value_out (value_out),
    .interrupt (interrupt)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] pout;
    logic [7:0]  vout;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic r, logic [7:0] a, logic [7:0] d,
                              logic [15:0] pout, logic [7:0] vout, string name);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.d = d; v.pout = pout; v.vout = vout; v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive strobes, let one posedge pass, sample 1 ns later.
  task automatic cyc(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    wen = w; ren = r; address = a; value_in = d;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Table: port_in fixed at 16'hC35A, flags clear, value_out 00 on entry.
    tbl.push_back(mk(1, 0, 8'h41, 8'h3C, 16'h3CA5, 8'h00, "wr_out1"));
    tbl.push_back(mk(1, 0, 8'h61, 8'h99, 16'h3CA5, 8'h00, "wr_outside"));
    tbl.push_back(mk(1, 0, 8'h40, 8'h77, 16'h3C77, 8'h00, "wr_out0"));
    tbl.push_back(mk(1, 0, 8'h42, 8'h11, 16'h3C77, 8'h00, "wr_off2_ign"));
    tbl.push_back(mk(0, 1, 8'h40, 8'h00, 16'h3C77, 8'h5A, "rd_in0"));
    tbl.push_back(mk(0, 1, 8'h5F, 8'h00, 16'h3C77, 8'h00, "rd_5f"));
    tbl.push_back(mk(0, 1, 8'h41, 8'h00, 16'h3C77, 8'hC3, "rd_in1"));
    tbl.push_back(mk(0, 0, 8'h41, 8'h00, 16'h3C77, 8'hC3, "hold"));
    tbl.push_back(mk(0, 1, 8'h42, 8'h00, 16'h3C77, 8'h00, "rd_in2_none"));
    tbl.push_back(mk(0, 1, 8'h48, 8'h00, 16'h3C77, RB ? 8'h77 : 8'h00, "rd_rdbk0"));
    tbl.push_back(mk(0, 1, 8'h49, 8'h00, 16'h3C77, RB ? 8'h3C : 8'h00, "rd_rdbk1"));
    tbl.push_back(mk(0, 1, 8'h4A, 8'h00, 16'h3C77, 8'h00, "rd_rdbk2_none"));
    tbl.push_back(mk(0, 1, 8'h41, 8'h00, 16'h3C77, 8'hC3, "rd_in1_again"));
    tbl.push_back(mk(0, 1, 8'h61, 8'h00, 16'h3C77, 8'h00, "rd_miss"));
    tbl.push_back(mk(1, 0, 8'h50, 8'hFF, 16'h3C77, 8'h00, "wr_mask"));
    tbl.push_back(mk(0, 1, 8'h50, 8'h00, 16'h3C77, 8'h03, "rd_mask"));
    tbl.push_back(mk(1, 1, 8'h41, 8'h55, 16'h5577, 8'h00, "wr_rd_same")); // addr shared below
    tbl.push_back(mk(0, 1, 8'h49, 8'h00, 16'h5577, RB ? 8'h55 : 8'h00, "rd_rdbk1_new"));
    tbl.push_back(mk(1, 0, 8'h50, 8'h00, 16'h5577, RB ? 8'h55 : 8'h00, "wr_mask0"));
    tbl.push_back(mk(0, 1, 8'h50, 8'h00, 16'h5577, 8'h00, "rd_mask0"));
    // Row "wr_rd_same" writes 8'h41 and reads 8'h41 concurrently: read gets synced input 1.
    tbl[16].vout = 8'hC3;

    rst = 1'b1; wen = 0; ren = 0; address = 0; value_in = 0;
    port_in = 16'hFFFF;
    idle(3);
    chk("rst_port_out", port_out, 16'hA5A5);
    chk("rst_value_out", {8'h00, value_out}, 16'h0000);
    chk("rst_irq", {15'h0, interrupt}, 16'h0000);
    rst = 1'b0;
    idle(6);
    cyc(0, 1, 8'h51, 8'h00);
    chk("no_flag_after_rst", {8'h00, value_out}, 16'h0000);

    // Both input bytes change -> both flags set
    port_in = 16'hC35A;
    idle(5);
    cyc(0, 1, 8'h51, 8'h00);
    chk("flags_both", {8'h00, value_out}, 16'h0003);
    cyc(1, 0, 8'h51, 8'h03);
    cyc(0, 1, 8'h51, 8'h00);
    chk("flags_cleared", {8'h00, value_out}, 16'h0000);

    foreach (tbl[i]) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      chk({tbl[i].name, "_pout"}, port_out, tbl[i].pout);
      chk({tbl[i].name, "_vout"}, {8'h00, value_out}, {8'h00, tbl[i].vout});
      chk({tbl[i].name, "_irq"}, {15'h0, interrupt}, 16'h0000);
    end

    // Prepare port 0 at 00 with mask off, then clear flags and enable mask bit 0
    port_in = 16'hC300;
    idle(5);
    cyc(1, 0, 8'h51, 8'h03);
    cyc(1, 0, 8'h50, 8'h01);
    idle(1);
    chk("irq_idle", {15'h0, interrupt}, 16'h0000);

    // Interrupt latency: 4 clocks from port_in change
    port_in = 16'hC301;
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      chk($sformatf("irq_lat_%0d", i), {15'h0, interrupt}, (i == 4) ? 16'h1 : 16'h0);
    end
    cyc(0, 1, 8'h51, 8'h00);
    chk("flag0_set", {8'h00, value_out}, 16'h0001);

    // Set/clear collision: W1C lands on the edge where the new change sets the flag
    port_in = 16'hC300;
    idle(2);
    cyc(1, 0, 8'h51, 8'h01);
    chk("collide_irq", {15'h0, interrupt}, 16'h0001);
    cyc(0, 1, 8'h51, 8'h00);
    chk("collide_flag", {8'h00, value_out}, 16'h0001);
    chk("collide_irq2", {15'h0, interrupt}, 16'h0001);

    // Clear with concurrent read returns pre-clear flags; irq drops a cycle later
    cyc(1, 1, 8'h51, 8'h01);
    chk("rd_preclear", {8'h00, value_out}, 16'h0001);
    chk("irq_lag", {15'h0, interrupt}, 16'h0001);
    cyc(0, 1, 8'h51, 8'h00);
    chk("rd_postclear", {8'h00, value_out}, 16'h0000);
    chk("irq_drop", {15'h0, interrupt}, 16'h0000);

    // Raise irq again, then reset mid-operation with concurrent write/read
    port_in = 16'hC301;
    idle(5);
    cyc(0, 1, 8'h51, 8'h00);
    chk("pre_rst_irq", {15'h0, interrupt}, 16'h0001);
    rst = 1'b1;
    cyc(1, 1, 8'h40, 8'h12);
    chk("midrst_pout", port_out, 16'hA5A5);
    chk("midrst_vout", {8'h00, value_out}, 16'h0000);
    chk("midrst_irq", {15'h0, interrupt}, 16'h0000);
    rst = 1'b0;
    idle(6);
    cyc(0, 1, 8'h51, 8'h00);
    chk("rearm_flags", {8'h00, value_out}, 16'h0000);
    cyc(0, 1, 8'h50, 8'h00);
    chk("rst_mask", {8'h00, value_out}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gio_bank.md
Name: gio_bank

Overview:
- Parametrised successor to the single-address output and input port pair.
- One instance serves an aligned 32-address window on the PicoBlaze port bus. It provides:
  - N_OUT clocked output registers.
  - N_IN synchronised input ports.
  - Per-input change detection with sticky flags.
  - A maskable, level interrupt to the processor.
- Sits between the pacoblaze core (port_id/out_port/in_port/write_strobe/read_strobe) and board GPIO.

Parameters:
- BASE_ADDR, 8'h00, window base; low 5 bits must be zero.
- N_OUT, 1, number of 8-bit output registers, range 1..8.
- N_IN, 1, number of 8-bit input ports, range 1..8.
- OUT_RST, 8'h00, reset value loaded into every output register.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- address  in  8  port address from core.
- value_in  in  8  write data from core.
- wen  in  1  write strobe, one cycle per write.
- ren  in  1  read strobe.
- port_in  in  8*N_IN  asynchronous GPIO inputs; port k = bits [8k+7:8k].
- port_out  out  8*N_OUT  output registers; port k = bits [8k+7:8k].
- value_out  out  8  registered read data to core.
- interrupt  out  1  registered level interrupt.

Behaviour:
- Reset:
  - port_out = {N_OUT{OUT_RST}}; value_out = 0; interrupt = 0.
  - Sync flops, previous-value regs, flags, mask and arm counter all clear to 0.
- Decode: hit = (address[7:5] == BASE_ADDR[7:5]); off = address[4:0].
- Write map (wen && hit), takes effect at next posedge:
  - off 0..N_OUT-1: out reg[off] <= value_in.
  - 0x10: mask <= value_in[N_IN-1:0].
  - 0x11: flags <= flags & ~value_in (write-1-to-clear).
  - Other offsets: ignored.
- Read map (ren && hit), value_out valid one cycle after ren:
  - off 0..N_IN-1: synced input[off].
  - 0x10: mask, zero-extended.
  - 0x11: flags, zero-extended.
  - Other offsets: 8'h00.
- ren && !hit: value_out <= 8'h00.
- ren low: value_out holds.
- Input path, per port:
  - 2-flop synchroniser, then prev register.
  - chg[k] = |(sync2[k] ^ prev[k]).
  - flags[k] set on chg[k].
- Set/clear collision: a set and a W1C clear on the same bit in the same cycle resolve to set.
- Arm counter:
  - 2-bit counter starts at 0 after reset and increments to 3, then saturates.
  - Change detection is enabled only when count == 3.
  - prev tracks sync2 every cycle regardless, so no spurious flags arise from reset-to-input transitions.
- Interrupt: interrupt <= |(flags & mask), registered, so 1-cycle lag.
  - Latency from port_in change to interrupt = 4 clk: 2 sync, 1 flag, 1 irq.
  - Deasserts one cycle after the flag is cleared or masked.
- Reset mid-operation overrides any concurrent wen/ren and re-arms the counter.
- wen and ren in the same cycle are independent. A read of 0x11 concurrent with a clear returns pre-clear flags.

Optional Feature:
- Macro GIO_READBACK_EN.
- Defined: reads at off 0x08+k (k<N_OUT) return out reg k.
- Undefined: those offsets read 8'h00 and no readback mux is built.

Decomposition:
- Package gio_pkg holds:
  - Offset constants GIO_OFF_MASK=5'h10, GIO_OFF_FLAGS=5'h11, GIO_OFF_RDBK=5'h08.
  - Window width constant (5).
  - Max-channel constant (8).
- Sub-module gio_sync_edge, instantiated N_IN times:
  - Contains the 2-flop sync, prev register and chg output, plus clk/rst/arm inputs.

Test Plan:
- Reset with OUT_RST=8'hA5, N_OUT=2 -> port_out=16'hA5A5, value_out=0, interrupt=0; port_in held at 8'hFF through reset -> flags stay 0.
- BASE_ADDR=8'h40: write 8'h3C to 8'h41 -> port_out[15:8]=8'h3C next cycle; write to 8'h61 (outside window) -> no change.
- port_in[7:0] 00->01 with mask=8'h01 -> flags read at 8'h51 = 8'h01; interrupt high exactly 4 clk after the change.
- Write 8'h01 to 8'h51 in the same cycle as a new port_in toggle reaching the flag -> flag remains 1, interrupt stays high.
- Read 8'h40 with port_in=8'h5A stable -> value_out=8'h5A one cycle after ren; read 8'h5F -> 8'h00.
- GIO_READBACK_EN defined: write 8'h77 to 8'h40, read 8'h48 -> 8'h77. Undefined: read 8'h48 -> 8'h00.
